lsu_mem_responder: RTL and testbench
====================================

Name: lsu_mem_responder

Overview:
- Parametrised data-side bus responder model for Ibex LSU benches; next generation of the fixed-pattern LSU stimulus block.
- Sits on the LSU data interface and plays the memory: grants requests after a configurable delay and returns in-order responses after a configurable latency.
- Backed by a small byte-enabled memory, supports multiple outstanding transactions, runtime response stall and address-range bus-error injection.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the backing memory (power of 2).
- MAX_OUTSTANDING, 4, response queue depth (power of 2, ≥1).
- GNT_DELAY, 0, extra cycles data_req_o must stay high before data_gnt_i.
- RESP_LATENCY, 1, minimum cycles from grant to rvalid (≥1).
- ERR_BASE, 32'hF000_0000, bus-error address base.
- ERR_MASK, 32'h0000_0000, bus-error address mask; 0 disables error injection.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- data_req_o  in  1  LSU request
- data_addr_o  in  32  LSU address
- data_we_o  in  1  LSU write enable
- data_be_o  in  4  LSU byte enables
- data_wdata_o  in  32  LSU write data
- data_gnt_i  out  1  grant to LSU
- data_rvalid_i  out  1  response valid
- data_rdata_i  out  32  read data
- data_bus_err_i  out  1  bus error, qualified by rvalid
- data_pmp_err_i  out  1  PMP error
- resp_stall_i  in  1  bench-driven response backpressure
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current queue occupancy

Behaviour:
- Reset, one clock, synchronous, active-high:
  - All outputs go to 0.
  - Queue is flushed and the delay counter is cleared.
  - Memory is cleared to 0.
  - Reset asserted mid-transaction drops every in-flight response; no rvalid appears for it afterwards.
- Grant FSM, states IDLE and WAIT:
  - IDLE → WAIT when data_req_o=1 and GNT_DELAY>0.
  - In WAIT, the counter increments each cycle while data_req_o=1.
  - data_req_o=0 in WAIT returns the FSM to IDLE and clears the counter.
- Grant condition: data_req_o=1, counter==GNT_DELAY, and queue not full.
  - data_gnt_i is combinational and lasts one cycle per transaction.
  - FSM then returns to IDLE.
  - With GNT_DELAY=0, back-to-back grants occur every cycle while req is held.
- Full queue: grant is withheld even if a pop happens in the same cycle. Counter saturates at GNT_DELAY meanwhile.
- Address decode:
  - Word index = data_addr_o[2 +: $clog2(MEM_WORDS)], wrapping modulo MEM_WORDS.
  - addr[1:0] is ignored; the LSU supplies aligned be.
- Error decode: err = (ERR_MASK!=0) && ((addr & ERR_MASK)==ERR_BASE).
- At grant cycle t:
  - Writes with !err update the selected bytes per data_be_o.
  - Reads capture the full memory word as it stands before that cycle's write, so read-after-write sees the earlier write.
  - Push entry {rdata (0 for writes or err), err, countdown=RESP_LATENCY-1}.
- Response queue:
  - FIFO, in order.
  - All entries' countdowns decrement each cycle, saturating at 0.
  - Head with countdown 0 and resp_stall_i=0 drives data_rvalid_i=1 for one cycle with data_rdata_i and data_bus_err_i, then pops.
  - Earliest rvalid is therefore cycle t+RESP_LATENCY.
  - Stall holds the head; rvalid stays 0.
  - data_rdata_i and data_bus_err_i are 0 whenever rvalid=0.
- Push and pop in the same cycle are both legal; outstanding_o is unchanged.
- outstanding_o reflects registered occupancy.

Optional Feature:
- LSU_RESP_PMP_INJ_EN defined:
  - Adds parameters PMP_BASE and PMP_MASK.
  - A request matching the PMP range gets data_pmp_err_i=1 combinationally in the request cycle, and data_gnt_i is never asserted for it.
  - No memory access and no queue entry.
  - FSM holds IDLE while that request persists.
- Undefined: data_pmp_err_i is tied to 0.

Decomposition:
- Package lsu_resp_pkg holds:
  - resp_entry_t struct {rdata[31:0], err, cnt}.
  - gnt_state_e enum {IDLE, WAIT}.
  - Width helper localparams.
- Sub-module lsu_resp_fifo: parametrised synchronous FIFO of resp_entry_t with per-entry countdown, head-ready flag, push/pop and count output.
- Memory and grant FSM stay in the top.

Test Plan:
- Defaults; write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then read 0x10 → gnt same cycle as each req; read rvalid one cycle after its grant with rdata=0xDEADBEEF, bus_err=0.
- GNT_DELAY=2, RESP_LATENCY=3; single read at cycle 5 → gnt at cycle 7, rvalid at cycle 10; write with be=4'b0010, wdata 0x0000AB00, over 0x11223344 → later read 0x1122AB44.
- MAX_OUTSTANDING=4, resp_stall_i=1, back-to-back reads → exactly 4 grants, outstanding_o=4, req held without gnt; release stall → 4 rvalids in grant order on consecutive cycles, then the 5th grant follows.
- ERR_BASE=0xF000_0000, ERR_MASK=0xF000_0000; write 0xF000_0004 then read 0x0000_0004 → write rvalid with bus_err=1; memory unchanged, read rdata=0; next read of 0x10 has bus_err=0.
- Reset asserted for 1 cycle with 3 entries queued → next cycle outstanding_o=0, no rvalid ever for the flushed entries; a read after reset returns 0.
- LSU_RESP_PMP_INJ_EN with PMP_MASK=0xFFFF_0000, PMP_BASE=0x8000_0000; read 0x8000_0010 → data_pmp_err_i=1 in the req cycle, no gnt, outstanding_o stays 0.

Source files
------------

// File: rtl/lsu_resp_pkg.sv
// Shared types for the LSU memory responder: response queue entry and grant FSM states.
package lsu_resp_pkg;

    // Countdown field width; RESP_LATENCY-1 must fit in it.
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [31:0]      rdata;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } resp_entry_t;

    typedef enum logic {
        IDLE,
        WAIT
    } gnt_state_e;

endpackage

// File: rtl/lsu_resp_fifo.sv
// In-order response queue; every entry counts down to zero and the head is ready at zero.
module lsu_resp_fifo
    import lsu_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  resp_entry_t            push_entry,
    input  logic                   pop,
    output resp_entry_t            head,
    output logic                   head_ready,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    resp_entry_t      slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Stale slots keep counting too; harmless since they are never read before being rewritten.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                slots[i] <= push_entry;
            end else if (slots[i].cnt != '0) begin
                slots[i].cnt <= slots[i].cnt - CNT_W'(1);
            end
        end
    end

    assign head       = slots[rd_ptr];
    assign head_ready = (count != '0) && (head.cnt == '0);
    assign full       = (count == OCC_W'(DEPTH));

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the Ibex LSU data port: delayed grant, latency-timed in-order responses.
// Optional LSU_RESP_PMP_INJ_EN adds PMP_BASE/PMP_MASK and refuses matching requests with data_pmp_err_i.
module lsu_mem_responder
    import lsu_resp_pkg::*;
#(
`ifdef LSU_RESP_PMP_INJ_EN
    parameter logic [31:0] PMP_BASE        = 32'h8000_0000,
    parameter logic [31:0] PMP_MASK        = 32'h0000_0000,
`endif
    parameter int unsigned MEM_WORDS       = 256,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter logic [31:0] ERR_BASE        = 32'hF000_0000,
    parameter logic [31:0] ERR_MASK        = 32'h0000_0000
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               data_req_o,
    input  logic [31:0]                        data_addr_o,
    input  logic                               data_we_o,
    input  logic [3:0]                         data_be_o,
    input  logic [31:0]                        data_wdata_o,
    output logic                               data_gnt_i,
    output logic                               data_rvalid_i,
    output logic [31:0]                        data_rdata_i,
    output logic                               data_bus_err_i,
    output logic                               data_pmp_err_i,
    input  logic                               resp_stall_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [31:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             pmp_hit;
    logic             req_ok;
    logic             q_full;
    logic             head_ready;
    logic             unused_head_cnt;
    resp_entry_t      new_entry;
    resp_entry_t      head;
    gnt_state_e       state;
    logic [31:0]      dly_cnt;

    assign idx      = data_addr_o[2 +: IDX_W];
    assign addr_err = (ERR_MASK != '0) && ((data_addr_o & ERR_MASK) == ERR_BASE);

`ifdef LSU_RESP_PMP_INJ_EN
    assign pmp_hit = (PMP_MASK != '0) && ((data_addr_o & PMP_MASK) == PMP_BASE);
`else
    assign pmp_hit = 1'b0;
`endif

    assign data_pmp_err_i = !rst_i && data_req_o && pmp_hit;
    assign req_ok         = data_req_o && !pmp_hit;
    // A full queue blocks the grant even when the head pops in the same cycle.
    assign data_gnt_i     = !rst_i && req_ok && (dly_cnt == GNT_DELAY) && !q_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            dly_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok && (GNT_DELAY > 0)) begin
                        state   <= WAIT;
                        dly_cnt <= 32'd1;
                    end
                end
                WAIT: begin
                    if (!req_ok || data_gnt_i) begin
                        state   <= IDLE;
                        dly_cnt <= '0;
                    end else if (dly_cnt != GNT_DELAY) begin
                        dly_cnt <= dly_cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dly_cnt <= '0;
                end
            endcase
        end
    end

    // Reads sample the word before this cycle's write lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
        end else if (data_gnt_i && data_we_o && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_o[b]) mem[idx][8*b +: 8] <= data_wdata_o[8*b +: 8];
            end
        end
    end

    assign new_entry = '{
        rdata: (data_we_o || addr_err) ? 32'h0 : mem[idx],
        err:   addr_err,
        cnt:   CNT_W'(RESP_LATENCY - 1)
    };

    lsu_resp_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (data_gnt_i),
        .push_entry (new_entry),
        .pop        (data_rvalid_i),
        .head       (head),
        .head_ready (head_ready),
        .full       (q_full),
        .count      (outstanding_o)
    );

    assign data_rvalid_i   = !rst_i && head_ready && !resp_stall_i;
    assign data_rdata_i    = data_rvalid_i ? head.rdata : 32'h0;
    assign data_bus_err_i  = data_rvalid_i && head.err;
    assign unused_head_cnt = ^head.cnt;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench: instance a (no delay, error window, depth 4) and instance b (delayed grant, latency 3).
module tb_lsu_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req, a_we, a_gnt, a_rvalid, a_berr, a_perr, a_stall;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic [2:0]  a_out;

    logic        b_req, b_we, b_gnt, b_rvalid, b_berr, b_perr, b_stall;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic [2:0]  b_out;

    int n_chk  = 0;
    int n_pass = 0;

    lsu_mem_responder #(
`ifdef LSU_RESP_PMP_INJ_EN
        .PMP_BASE        (32'h8000_0000),
        .PMP_MASK        (32'hFFFF_0000),
`endif
        .MEM_WORDS       (256),
        .MAX_OUTSTANDING (4),
        .GNT_DELAY       (0),
        .RESP_LATENCY    (1),
        .ERR_BASE        (32'hF000_0000),
        .ERR_MASK        (32'hF000_0000)
    ) u_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_req_o     (a_req),
        .data_addr_o    (a_addr),
        .data_we_o      (a_we),
        .data_be_o      (a_be),
        .data_wdata_o   (a_wdata),
        .data_gnt_i     (a_gnt),
        .data_rvalid_i  (a_rvalid),
        .data_rdata_i   (a_rdata),
        .data_bus_err_i (a_berr),
        .data_pmp_err_i (a_perr),
        .resp_stall_i   (a_stall),
        .outstanding_o  (a_out)
    );

    lsu_mem_responder #(
        .MEM_WORDS       (256),
        .MAX_OUTSTANDING (4),
        .GNT_DELAY       (2),
        .RESP_LATENCY    (3)
    ) u_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_req_o     (b_req),
        .data_addr_o    (b_addr),
        .data_we_o      (b_we),
        .data_be_o      (b_be),
        .data_wdata_o   (b_wdata),
        .data_gnt_i     (b_gnt),
        .data_rvalid_i  (b_rvalid),
        .data_rdata_i   (b_rdata),
        .data_bus_err_i (b_berr),
        .data_pmp_err_i (b_perr),
        .resp_stall_i   (b_stall),
        .outstanding_o  (b_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        a_req = req; a_we = we; a_addr = addr; a_be = be; a_wdata = wdata;
    endtask

    task automatic b_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        b_req = req; b_we = we; b_addr = addr; b_be = be; b_wdata = wdata;
    endtask

    // One full transaction on b: hold req until granted, then wait for its response.
    task automatic b_xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output logic got, output logic [31:0] rdata);
        logic granted = 1'b0;
        got   = 1'b0;
        rdata = '0;
        b_set(1'b1, we, addr, be, wdata);
        for (int i = 0; i < 10 && !granted; i++) begin
            @(negedge clk);
            granted = b_gnt;
            tick();
        end
        b_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 10 && granted && !got; i++) begin
            @(negedge clk);
            if (b_rvalid) begin
                got   = 1'b1;
                rdata = b_rdata;
            end
            tick();
        end
    endtask

    logic [31:0] vals [4];
    logic        got;
    logic [31:0] rd;
    int          k, ngnt, nrv;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_set(0, 0, 0, 0, 0);
        b_set(0, 0, 0, 0, 0);
        a_stall = 1'b0;
        b_stall = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        @(negedge clk);
        check_eq("rst_a_gnt",    a_gnt,    0);
        check_eq("rst_a_rvalid", a_rvalid, 0);
        check_eq("rst_a_out",    a_out,    0);
        check_eq("rst_b_out",    b_out,    0);
        check_eq("rst_a_rdata",  a_rdata,  0);
        tick();

        // Write then read back, zero grant delay and latency 1.
        a_set(1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk); check_eq("wr_gnt", a_gnt, 1); tick();
        a_set(1, 0, 32'h10, 4'hF, 32'h0);
        @(negedge clk);
        check_eq("rd_gnt", a_gnt, 1);
        check_eq("wr_rvalid", a_rvalid, 1);
        check_eq("wr_rdata", a_rdata, 0);
        tick();
        a_set(0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("rd_rvalid", a_rvalid, 1);
        check_eq("rd_rdata", a_rdata, 32'hDEAD_BEEF);
        check_eq("rd_berr", a_berr, 0);
        tick();
        @(negedge clk); check_eq("idle_out", a_out, 0); tick();

        // Error window: write suppressed and flagged.
        a_set(1, 1, 32'hF000_0004, 4'hF, 32'h1234_5678);
        @(negedge clk); check_eq("err_wr_gnt", a_gnt, 1); tick();
        a_set(1, 0, 32'h0000_0004, 4'hF, 32'h0);
        @(negedge clk);
        check_eq("err_wr_rvalid", a_rvalid, 1);
        check_eq("err_wr_berr", a_berr, 1);
        tick();
        a_set(1, 0, 32'h10, 4'hF, 32'h0);
        @(negedge clk);
        check_eq("err_rd4_rdata", a_rdata, 0);
        check_eq("err_rd4_berr", a_berr, 0);
        tick();
        a_set(0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("err_rd10_rdata", a_rdata, 32'hDEAD_BEEF);
        check_eq("err_rd10_berr", a_berr, 0);
        tick();

        // Preload four words for the stall test.
        for (int i = 0; i < 4; i++) begin
            vals[i] = 32'hC0DE_0000 + i;
            a_set(1, 1, 32'h20 + 4 * i, 4'hF, vals[i]);
            tick();
        end
        a_set(0, 0, 0, 0, 0);
        repeat (2) tick();

        // Stalled responses fill the queue, then drain in order.
        a_stall = 1'b1;
        k = 0; ngnt = 0;
        for (int i = 0; i < 6; i++) begin
            a_set(1, 0, 32'h20 + 4 * k, 4'hF, 32'h0);
            @(negedge clk);
            if (a_gnt) begin ngnt++; k++; end
            tick();
        end
        check_eq("stall_ngnt", ngnt, 4);
        @(negedge clk);
        check_eq("stall_full_gnt", a_gnt, 0);
        check_eq("stall_out", a_out, 4);
        check_eq("stall_rvalid", a_rvalid, 0);
        tick();
        a_stall = 1'b0;
        @(negedge clk);
        check_eq("drain0_rdata", a_rdata, vals[0]);
        check_eq("drain0_gnt", a_gnt, 0);
        tick();
        @(negedge clk);
        check_eq("drain1_rdata", a_rdata, vals[1]);
        check_eq("drain1_gnt", a_gnt, 1);
        tick();
        a_set(0, 0, 0, 0, 0);
        @(negedge clk); check_eq("drain2_rdata", a_rdata, vals[2]); tick();
        @(negedge clk); check_eq("drain3_rdata", a_rdata, vals[3]); tick();
        @(negedge clk);
        check_eq("fifth_rvalid", a_rvalid, 1);
        check_eq("fifth_rdata", a_rdata, 0);
        tick();
        @(negedge clk); check_eq("drain_out", a_out, 0); tick();

        // Reset with three queued responses.
        a_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_set(1, 0, 32'h10, 4'hF, 32'h0);
            tick();
        end
        a_set(0, 0, 0, 0, 0);
        @(negedge clk); check_eq("pre_rst_out", a_out, 3); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_stall = 1'b0;
        @(negedge clk); check_eq("post_rst_out", a_out, 0); tick();
        nrv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_rvalid) nrv++;
            tick();
        end
        check_eq("flushed_rvalids", nrv, 0);
        a_set(1, 0, 32'h10, 4'hF, 32'h0);
        @(negedge clk); check_eq("post_rst_gnt", a_gnt, 1); tick();
        a_set(0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("post_rst_rvalid", a_rvalid, 1);
        check_eq("post_rst_rdata", a_rdata, 0);
        tick();

        // PMP injection (or its absence in the default build).
        a_set(1, 0, 32'h8000_0010, 4'hF, 32'h0);
`ifdef LSU_RESP_PMP_INJ_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("pmp_err", a_perr, 1);
            check_eq("pmp_gnt", a_gnt, 0);
            tick();
        end
        a_set(0, 0, 0, 0, 0);
        @(negedge clk); check_eq("pmp_out", a_out, 0); tick();
`else
        @(negedge clk);
        check_eq("pmp_tied", a_perr, 0);
        check_eq("pmp_off_gnt", a_gnt, 1);
        tick();
        a_set(0, 0, 0, 0, 0);
        tick();
`endif

        // Instance b: grant two cycles after req, response three after grant.
        b_set(1, 0, 32'h40, 4'hF, 32'h0);
        @(negedge clk); check_eq("b_gnt_c0", b_gnt, 0); tick();
        @(negedge clk); check_eq("b_gnt_c1", b_gnt, 0); tick();
        @(negedge clk); check_eq("b_gnt_c2", b_gnt, 1); tick();
        b_set(0, 0, 0, 0, 0);
        @(negedge clk); check_eq("b_rv_t1", b_rvalid, 0); tick();
        @(negedge clk); check_eq("b_rv_t2", b_rvalid, 0); tick();
        @(negedge clk);
        check_eq("b_rv_t3", b_rvalid, 1);
        check_eq("b_rd_t3", b_rdata, 0);
        tick();

        b_xact(1, 32'h40, 4'hF, 32'h1122_3344, got, rd);
        check_eq("b_wr_full_resp", got, 1);
        b_xact(1, 32'h40, 4'b0010, 32'h0000_AB00, got, rd);
        check_eq("b_wr_byte_resp", got, 1);
        b_xact(0, 32'h40, 4'hF, 32'h0, got, rd);
        check_eq("b_rd_resp", got, 1);
        check_eq("b_rd_merge", rd, 32'h1122_AB44);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
